// File: rtl/conv_window_mac.sv
// Valid-mode 2-D convolution over a captured padded map using one time-shared
// multiply-accumulate unit; results stream out over a ready/valid handshake.
module conv_window_mac #(
  parameter int SIZE = 5,
  parameter int K    = 3,
  localparam int N   = 2*SIZE - 1,
  localparam int M   = N - K + 1,
  localparam int RW  = (M > 1) ? $clog2(M) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   array_in [0:N-1][0:N-1],
  input  logic [31:0]   kernel   [0:K-1][0:K-1],
  input  logic          start,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic [RW-1:0] out_row,
  output logic [RW-1:0] out_col,
  output logic          busy,
  output logic          done
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAC, EMIT, DONE} state_t;

  state_t        state;
  logic [31:0]   img [0:N-1][0:N-1];
  logic [31:0]   ker [0:K-1][0:K-1];
  logic [RW-1:0] r, c;
  logic [KW-1:0] ki, kj;
  logic [31:0]   acc;
  logic [NW-1:0] ir, ic;
  logic [31:0]   prod, sum;

  // Low 32 bits of a product are the same for signed and unsigned operands,
  // so a plain 32-bit multiply gives the modulo-2^32 signed result.
  always_comb begin
    ir   = NW'(r) + NW'(ki);
    ic   = NW'(c) + NW'(kj);
    prod = img[ir][ic] * ker[ki][kj];
    sum  = acc + prod;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      acc       <= '0;
      r         <= '0;
      c         <= '0;
      ki        <= '0;
      kj        <= '0;
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++)
          img[i][j] <= '0;
      for (int unsigned i = 0; i < K; i++)
        for (int unsigned j = 0; j < K; j++)
          ker[i][j] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            img   <= array_in;
            ker   <= kernel;
            r     <= '0;
            c     <= '0;
            ki    <= '0;
            kj    <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end

        MAC: begin
          acc <= sum;
          if (kj == KW'(K-1)) begin
            kj <= '0;
            if (ki == KW'(K-1)) begin
              ki        <= '0;
              out_data  <= sum;
              out_row   <= r;
              out_col   <= c;
              out_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              ki <= ki + 1'b1;
            end
          end else begin
            kj <= kj + 1'b1;
          end
        end

        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (r == RW'(M-1) && c == RW'(M-1)) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              if (c == RW'(M-1)) begin
                c <= '0;
                r <= r + 1'b1;
              end else begin
                c <= c + 1'b1;
              end
              acc   <= '0;
              ki    <= '0;
              kj    <= '0;
              state <= MAC;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed/randomized bench for conv_window_mac against a loop-based
// convolution model over a snapshot of the inputs taken at start.
module tb_conv_window_mac;

  localparam int SIZE = 5;
  localparam int K    = 3;
  localparam int N    = 2*SIZE - 1;
  localparam int M    = N - K + 1;
  localparam int KK   = K*K;
  localparam int RW   = $clog2(M);

  logic          clk = 1'b0;
  logic          reset, start, out_ready;
  logic          out_valid, busy, done;
  logic [31:0]   array_in [0:N-1][0:N-1];
  logic [31:0]   kernel   [0:K-1][0:K-1];
  logic [31:0]   out_data;
  logic [RW-1:0] out_row, out_col;

  logic [31:0]   m_img [0:N-1][0:N-1];
  logic [31:0]   m_ker [0:K-1][0:K-1];
  logic [31:0]   res   [0:M*M-1];
  int            checks = 0;
  int            failures = 0;
  int            nres;

  always #5 clk = ~clk;

  conv_window_mac #(.SIZE(SIZE), .K(K)) dut (
    .clk(clk), .reset(reset), .array_in(array_in), .kernel(kernel),
    .start(start), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_at(input int r, input int c);
    logic [31:0] s = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += m_img[r+i][c+j] * m_ker[i][j];
    return s;
  endfunction

  task automatic clear_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        array_in[i][j] = '0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        kernel[i][j] = '0;
  endtask

  task automatic random_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        array_in[i][j] = $urandom;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        kernel[i][j] = $urandom;
  endtask

  task automatic ones_inputs();
    clear_inputs();
    for (int i = 0; i < SIZE; i++)
      for (int j = 0; j < SIZE; j++)
        array_in[i][j] = 32'd1;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        kernel[i][j] = 32'd1;
  endtask

  // Runs one job; stall holds off the first result, poke pulses start with a
  // new map mid-MAC, rst_k asserts reset while result rst_k is on offer.
  task automatic run_job(input string tag, input bit stall, input bit poke, input int rst_k);
    int  e, last_hs, w;
    bit  stop;
    m_img = array_in;
    m_ker = kernel;
    nres = 0;
    stop = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    e = 0;
    last_hs = 0;
    chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    for (int k = 0; k < M*M; k++) begin
      w = 0;
      while (!out_valid && w < 4*KK) begin
        if (poke && k == 0 && e == 3) begin
          random_inputs();
          start = 1'b1;
        end else begin
          start = 1'b0;
        end
        tick();
        e++;
        w++;
      end
      start = 1'b0;
      chk({tag, "_latency"}, e - last_hs, KK);
      if (!out_valid) begin
        stop = 1'b1;
        break;
      end
      chk({tag, "_data"}, out_data, ref_at(k / M, k % M));
      chk({tag, "_row"}, {29'd0, out_row}, k / M);
      chk({tag, "_col"}, {29'd0, out_col}, k % M);
      res[k] = out_data;
      nres++;
      if (k == rst_k) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk({tag, "_rst_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_rst_data"}, out_data, 32'd0);
        chk({tag, "_rst_row"}, {29'd0, out_row}, 32'd0);
        chk({tag, "_rst_col"}, {29'd0, out_col}, 32'd0);
        chk({tag, "_rst_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_rst_done"}, {31'd0, done}, 32'd0);
        stop = 1'b1;
        break;
      end
      if (stall && k == 0) begin
        out_ready = 1'b0;
        for (int s = 0; s < 20; s++) begin
          tick();
          e++;
          chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
          chk({tag, "_stall_data"}, out_data, ref_at(0, 0));
          chk({tag, "_stall_rowcol"}, {26'd0, out_row, out_col}, 32'd0);
        end
        out_ready = 1'b1;
      end
      tick();
      e++;
      last_hs = e;
    end
    if (!stop) begin
      chk({tag, "_count"}, nres, M*M);
      chk({tag, "_final_edge"}, last_hs, M*M*(KK+1) + (stall ? 20 : 0));
      chk({tag, "_done_hi"}, {31'd0, done}, 32'd1);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      tick();
      chk({tag, "_done_lo"}, {31'd0, done}, 32'd0);
      chk({tag, "_busy_lo"}, {31'd0, busy}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    clear_inputs();
    tick();
    start = 1'b1;
    tick();
    tick();
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    chk("reset_rowcol", {26'd0, out_row, out_col}, 32'd0);
    start = 1'b0;
    reset = 1'b1;
    tick();

    ones_inputs();
    run_job("ones", 1'b0, 1'b0, -1);
    chk("ones_0_0", res[0], 32'd9);
    chk("ones_2_2", res[2*M+2], 32'd9);
    chk("ones_3_3", res[3*M+3], 32'd4);
    chk("ones_4_4", res[4*M+4], 32'd1);
    chk("ones_6_6", res[6*M+6], 32'd0);

    clear_inputs();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        array_in[i][j] = 10*i + j;
    kernel[1][1] = 32'd1;
    run_job("ident", 1'b0, 1'b0, -1);
    for (int k = 0; k < M*M; k++)
      chk("ident_val", res[k], 10*(k/M + 1) + (k%M + 1));
    chk("ident_0_0", res[0], 32'd11);
    chk("ident_6_6", res[M*M-1], 32'd77);

    ones_inputs();
    run_job("stall", 1'b1, 1'b0, -1);

    clear_inputs();
    array_in[0][0] = 32'hFFFF_FFFF;
    kernel[0][0] = 32'd2;
    run_job("signed", 1'b0, 1'b0, -1);
    chk("signed_0_0", res[0], 32'hFFFF_FFFE);

    clear_inputs();
    array_in[0][0] = 32'h8000_0000;
    array_in[0][1] = 32'h8000_0000;
    kernel[0][0] = 32'd1;
    kernel[0][1] = 32'd1;
    run_job("wrap", 1'b0, 1'b0, -1);
    chk("wrap_0_0", res[0], 32'h0000_0000);

    random_inputs();
    run_job("midrst", 1'b0, 1'b0, 10);
    chk("midrst_count", nres, 11);
    tick();
    random_inputs();
    run_job("restart", 1'b0, 1'b0, -1);

    random_inputs();
    run_job("poke", 1'b0, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_window_mac.md
# conv_window_mac

Sequential convolution stage that sits directly downstream of the zero-padding stage. It captures one padded N×N feature map (N = 2·SIZE−1) and a K×K kernel on `start`, then computes the valid-mode 2-D convolution with a single time-shared multiply-accumulate unit. It streams the M×M results (M = N−K+1) in row-major order over a ready/valid handshake and pulses `done` after the last result is accepted.

## Interface
- `SIZE`, default 5: unpadded map dimension; padded input dimension N = 2·SIZE−1 (default 9).
- `K`, default 3: kernel dimension; constraint 1 ≤ K ≤ N; output dimension M = N−K+1 (default 7).
- `clk`  input  1  sole clock; all state changes on its rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on rising `clk`.
- `array_in`  input  32 × [0:N−1][0:N−1]  padded map, as driven by the pad stage's registered output.
- `kernel`  input  32 × [0:K−1][0:K−1]  kernel weights.
- `start`  input  1  begin a job; honoured only in IDLE.
- `out_valid`  output  1  `out_data`, `out_row` and `out_col` hold a result.
- `out_ready`  input  1  consumer accepts the result when high together with `out_valid`.
- `out_data`  output  32  convolution result.
- `out_row`  output  clog2(M)  result row index.
- `out_col`  output  clog2(M)  result column index.
- `busy`  output  1  high in every state except IDLE.
- `done`  output  1  one-cycle pulse after the final result is accepted.

## Operation
- FSM states: IDLE, MAC, EMIT, DONE.
- **IDLE**
  - On `start`=1, copy `array_in` and `kernel` into internal registers.
  - Clear window indices (r, c), kernel indices (ki, kj) and accumulator; go to MAC.
  - Later changes on the input ports do not affect the job.
- **MAC**
  - Each cycle: acc ← acc + img[r+ki][c+kj] · ker[ki][kj].
  - ki/kj advance row-major: kj runs fastest.
  - After the K·K-th term, register the result into `out_data`, load `out_row`=r and `out_col`=c, and go to EMIT.
- **EMIT**
  - `out_valid`=1. `out_data`, `out_row` and `out_col` stay stable until the handshake.
  - On `out_ready`=1:
    - if (r, c) = (M−1, M−1), go to DONE;
    - otherwise advance c, wrapping to 0 and incrementing r; clear acc, ki, kj; go to MAC.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- **Arithmetic**
  - Operands are two's-complement signed 32-bit.
  - Each product and the accumulation are kept modulo 2^32: the low 32 bits of the exact sum. No saturation and no overflow flag.
- `start` while `busy`=1 is ignored and is not queued.
- **Reset** (`reset`=0 at a rising edge, in any state, including mid-job):
  - go to IDLE;
  - `out_valid`, `busy`, `done` = 0;
  - `out_data`, `out_row`, `out_col` = 0;
  - clear accumulator, indices and captured arrays.
  - Reset takes priority over `start` in the same cycle.

## Timing
- Edge E0 samples `start`=1 in IDLE. `busy` is high from after E0 until DONE exits.
- The first `out_valid` rises after edge E0+K·K (default E0+9).
- Handshake completes at an edge where `out_valid` and `out_ready` are both 1.
- After an accepted handshake, the next `out_valid` rises K·K edges later.
- Minimum per-result period is K·K+1 cycles.
- With `out_ready` tied high:
  - the final handshake occurs at edge E0 + M²·(K·K+1) (default E0+490);
  - `done` is high for the following cycle;
  - `busy` falls one cycle after that.
- `out_ready` low stalls the FSM in EMIT indefinitely. Output registers must not change during the stall.
- A new `start` is accepted no earlier than the first cycle back in IDLE.

## Test plan
- **All-ones, SIZE=5, K=3.** Stimulus: `array_in` ones in rows/cols 0..4 and zero elsewhere; all-ones kernel; `out_ready`=1. Required: 49 results in row-major order; (0,0)=9, (2,2)=9, (3,3)=4, (4,4)=1, (6,6)=0; `done` pulse at E0+491.
- **Identity kernel.** Stimulus: `kernel`[1][1]=1, all other weights 0; `array_in`[i][j]=10·i+j. Required: `out_data`=10·(r+1)+(c+1) for every (r,c), e.g. (0,0)=11 and (6,6)=77.
- **Backpressure.** Stimulus: hold `out_ready`=0 for 20 cycles on the first result. Required: `out_valid`, `out_data`=9 and `out_row`/`out_col`=0 stay stable throughout; the next `out_valid` rises exactly 9 edges after the handshake.
- **Signed and wrap arithmetic.**
  - Stimulus: window (0,0) containing −1 at [0][0] with weight 2. Required: `out_data`=0xFFFFFFFE.
  - Stimulus: two 0x80000000 values with weight 1. Required: `out_data`=0x00000000.
- **Reset mid-job.** Stimulus: drive `reset`=0 while in EMIT after the 10th result. Required: next cycle all outputs are 0 and `busy`=0; a fresh `start` then restarts at (0,0) with correct values.
- **Start while busy.** Stimulus: pulse `start` during MAC with a different `array_in`. Required: no effect; results match the originally captured map, and exactly 49 results are produced.
